ham_secded_fix: RTL and testbench

//  Parametrised SECDED successor to the single-cycle Hamming fixer: extended Hamming codeword in, corrected codeword out.

---
 rtl/ham_secded_fix.sv | 156 +++++++++++++++
 tb/tb_ham_secded_fix.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/ham_secded_fix.sv
// Two-stage SECDED corrector for extended Hamming codewords with a valid/ready
// handshake and saturating counters of corrected and uncorrectable words.
module ham_secded_fix #(
  parameter int PAR_W = 4,
  parameter int CNT_W = 16
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic                    correct_en,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [(2**PAR_W)-1:0]   in_code,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [(2**PAR_W)-1:0]   out_code,
  output logic [PAR_W-1:0]        out_syndrome,
  output logic                    out_corrected,
  output logic                    out_double,
  input  logic                    clear_counts,
  output logic [CNT_W-1:0]        corr_count,
  output logic [CNT_W-1:0]        double_count
);

  localparam int CODE_W = (2**PAR_W) - 1;

  // XOR of the positions of every set bit above the overall-parity bit
  function automatic logic [PAR_W-1:0] calc_syndrome(input logic [CODE_W:0] c);
    logic [PAR_W-1:0] s;
    s = '0;
    for (int i = 1; i <= CODE_W; i++) begin
      if (c[i]) s = s ^ PAR_W'(i);
    end
    return s;
  endfunction

  // A syndrome of zero with odd parity points at bit 0, so one flip covers both cases
  function automatic logic [CODE_W:0] fix_word(input logic [CODE_W:0] c,
                                               input logic [PAR_W-1:0] s,
                                               input logic             p,
                                               input logic             en);
    logic [CODE_W:0] w;
    w = c;
    if (en && p) w[s] = ~w[s];
    return w;
  endfunction

  logic              s1_vld_q, s1_vld_d;
  logic [CODE_W:0]   s1_code_q, s1_code_d;
  logic [PAR_W-1:0]  s1_syn_q, s1_syn_d;
  logic              s1_par_q, s1_par_d;
  logic              s1_cen_q, s1_cen_d;

  logic              s2_vld_q, s2_vld_d;
  logic [CODE_W:0]   s2_code_q, s2_code_d;
  logic [PAR_W-1:0]  s2_syn_q, s2_syn_d;
  logic              s2_corr_q, s2_corr_d;
  logic              s2_dbl_q, s2_dbl_d;

  logic [CNT_W-1:0]  corr_cnt_q, corr_cnt_d;
  logic [CNT_W-1:0]  dbl_cnt_q, dbl_cnt_d;

  logic              s2_adv;
  logic              xfer;

  assign s2_adv   = !s2_vld_q || out_ready;
  assign in_ready = !s1_vld_q || s2_adv;
  assign xfer     = s2_vld_q && out_ready;

  // Stage 1: capture the word with its syndrome and overall parity
  always_comb begin
    s1_vld_d  = s1_vld_q;
    s1_code_d = s1_code_q;
    s1_syn_d  = s1_syn_q;
    s1_par_d  = s1_par_q;
    s1_cen_d  = s1_cen_q;
    if (in_ready) begin
      s1_vld_d = in_valid;
      if (in_valid) begin
        s1_code_d = in_code;
        s1_syn_d  = calc_syndrome(in_code);
        s1_par_d  = ^in_code;
        s1_cen_d  = correct_en;
      end
    end
  end

  // Stage 2: classify and apply the correction
  always_comb begin
    s2_vld_d  = s2_vld_q;
    s2_code_d = s2_code_q;
    s2_syn_d  = s2_syn_q;
    s2_corr_d = s2_corr_q;
    s2_dbl_d  = s2_dbl_q;
    if (s2_adv) begin
      s2_vld_d = s1_vld_q;
      if (s1_vld_q) begin
        s2_code_d = fix_word(s1_code_q, s1_syn_q, s1_par_q, s1_cen_q);
        s2_syn_d  = s1_syn_q;
        s2_corr_d = s1_par_q;
        s2_dbl_d  = !s1_par_q && (s1_syn_q != '0);
      end
    end
  end

  // Counters advance only when the consumer takes a flagged word; clear has priority
  always_comb begin
    corr_cnt_d = corr_cnt_q;
    dbl_cnt_d  = dbl_cnt_q;
    if (clear_counts) begin
      corr_cnt_d = '0;
      dbl_cnt_d  = '0;
    end else if (xfer) begin
      if (s2_corr_q && (corr_cnt_q != '1)) corr_cnt_d = corr_cnt_q + 1'b1;
      if (s2_dbl_q && (dbl_cnt_q != '1))   dbl_cnt_d  = dbl_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      s1_vld_q   <= 1'b0;
      s1_code_q  <= '0;
      s1_syn_q   <= '0;
      s1_par_q   <= 1'b0;
      s1_cen_q   <= 1'b0;
      s2_vld_q   <= 1'b0;
      s2_code_q  <= '0;
      s2_syn_q   <= '0;
      s2_corr_q  <= 1'b0;
      s2_dbl_q   <= 1'b0;
      corr_cnt_q <= '0;
      dbl_cnt_q  <= '0;
    end else begin
      s1_vld_q   <= s1_vld_d;
      s1_code_q  <= s1_code_d;
      s1_syn_q   <= s1_syn_d;
      s1_par_q   <= s1_par_d;
      s1_cen_q   <= s1_cen_d;
      s2_vld_q   <= s2_vld_d;
      s2_code_q  <= s2_code_d;
      s2_syn_q   <= s2_syn_d;
      s2_corr_q  <= s2_corr_d;
      s2_dbl_q   <= s2_dbl_d;
      corr_cnt_q <= corr_cnt_d;
      dbl_cnt_q  <= dbl_cnt_d;
    end
  end

  assign out_valid     = s2_vld_q;
  assign out_code      = s2_code_q;
  assign out_syndrome  = s2_syn_q;
  assign out_corrected = s2_corr_q;
  assign out_double    = s2_dbl_q;
  assign corr_count    = corr_cnt_q;
  assign double_count  = dbl_cnt_q;

endmodule

// File: tb/tb_ham_secded_fix.sv
// Directed bench for ham_secded_fix: a 16-bit-counter instance plus a 2-bit-counter
// instance on the same stimulus, so counter saturation is visible.
module tb_ham_secded_fix;

  logic        clock = 1'b0;
  logic        reset_n, correct_en, in_valid, out_ready, clear_counts;
  logic [15:0] in_code;

  logic        in_ready, out_valid, out_corrected, out_double;
  logic [15:0] out_code;
  logic [3:0]  out_syndrome;
  logic [15:0] corr_count, double_count;

  logic        in_ready2, out_valid2, out_corrected2, out_double2;
  logic [15:0] out_code2;
  logic [3:0]  out_syndrome2;
  logic [1:0]  corr_count2, double_count2;

  int checks = 0;
  int failures = 0;

  always #5 clock = ~clock;

  ham_secded_fix #(.PAR_W(4), .CNT_W(16)) dut (
    .clock(clock), .reset_n(reset_n), .correct_en(correct_en),
    .in_valid(in_valid), .in_ready(in_ready), .in_code(in_code),
    .out_valid(out_valid), .out_ready(out_ready), .out_code(out_code),
    .out_syndrome(out_syndrome), .out_corrected(out_corrected),
    .out_double(out_double), .clear_counts(clear_counts),
    .corr_count(corr_count), .double_count(double_count)
  );

  ham_secded_fix #(.PAR_W(4), .CNT_W(2)) dut2 (
    .clock(clock), .reset_n(reset_n), .correct_en(correct_en),
    .in_valid(in_valid), .in_ready(in_ready2), .in_code(in_code),
    .out_valid(out_valid2), .out_ready(out_ready), .out_code(out_code2),
    .out_syndrome(out_syndrome2), .out_corrected(out_corrected2),
    .out_double(out_double2), .clear_counts(clear_counts),
    .corr_count(corr_count2), .double_count(double_count2)
  );

  task automatic test_reset();
    reset_n = 1'b0; correct_en = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    clear_counts = 1'b0; in_code = 16'h0000;
    repeat (2) @(posedge clock);
    #1;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rst_out_valid got=%0h exp=0", out_valid); end
    checks++; if (out_code !== 16'h0000) begin failures++; $display("FAIL rst_out_code got=%0h exp=0", out_code); end
    checks++; if (out_syndrome !== 4'h0) begin failures++; $display("FAIL rst_syndrome got=%0h exp=0", out_syndrome); end
    checks++; if ({out_corrected, out_double} !== 2'b00) begin failures++; $display("FAIL rst_flags got=%0b exp=00", {out_corrected, out_double}); end
    checks++; if (corr_count !== 16'h0 || double_count !== 16'h0) begin failures++; $display("FAIL rst_counts got=%0h/%0h exp=0/0", corr_count, double_count); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL rst_in_ready got=%0h exp=1", in_ready); end
    reset_n = 1'b1;
    @(posedge clock); #1;
  endtask

  task automatic test_clean();
    logic [15:0] vin [2] = '{16'h0000, 16'h000F};
    for (int i = 0; i < 2; i++) begin
      correct_en = 1'b1; out_ready = 1'b1; in_code = vin[i]; in_valid = 1'b1;
      @(posedge clock); #1;
      in_valid = 1'b0;
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL clean_latency_early got=%0h exp=0", out_valid); end
      @(posedge clock); #1;
      checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL clean_latency got=%0h exp=1", out_valid); end
      checks++; if (out_code !== vin[i]) begin failures++; $display("FAIL clean_code got=%0h exp=%0h", out_code, vin[i]); end
      checks++; if (out_syndrome !== 4'h0) begin failures++; $display("FAIL clean_syndrome got=%0h exp=0", out_syndrome); end
      checks++; if ({out_corrected, out_double} !== 2'b00) begin failures++; $display("FAIL clean_flags got=%0b exp=00", {out_corrected, out_double}); end
      @(posedge clock); #1;
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL clean_drained got=%0h exp=0", out_valid); end
    end
  endtask

  task automatic test_single();
    logic [15:0] vin  [3] = '{16'h0020, 16'h0001, 16'h0007};
    logic [15:0] vexp [3] = '{16'h0000, 16'h0000, 16'h000F};
    logic [3:0]  vsyn [3] = '{4'd5, 4'd0, 4'd3};
    for (int i = 0; i < 3; i++) begin
      correct_en = 1'b1; out_ready = 1'b1; in_code = vin[i]; in_valid = 1'b1;
      @(posedge clock); #1;
      in_valid = 1'b0;
      @(posedge clock); #1;
      checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL single_valid got=%0h exp=1", out_valid); end
      checks++; if (out_code !== vexp[i]) begin failures++; $display("FAIL single_code got=%0h exp=%0h", out_code, vexp[i]); end
      checks++; if (out_syndrome !== vsyn[i]) begin failures++; $display("FAIL single_syndrome got=%0h exp=%0h", out_syndrome, vsyn[i]); end
      checks++; if ({out_corrected, out_double} !== 2'b10) begin failures++; $display("FAIL single_flags got=%0b exp=10", {out_corrected, out_double}); end
      @(posedge clock); #1;
    end
  endtask

  task automatic test_double();
    logic [15:0] vin  [2] = '{16'h0028, 16'h0020};
    logic        vcen [2] = '{1'b1, 1'b0};
    logic [3:0]  vsyn [2] = '{4'd6, 4'd5};
    logic [1:0]  vflg [2] = '{2'b01, 2'b10};
    for (int i = 0; i < 2; i++) begin
      correct_en = vcen[i]; out_ready = 1'b1; in_code = vin[i]; in_valid = 1'b1;
      @(posedge clock); #1;
      in_valid = 1'b0; correct_en = 1'b1;
      @(posedge clock); #1;
      checks++; if (out_code !== vin[i]) begin failures++; $display("FAIL dbl_code got=%0h exp=%0h", out_code, vin[i]); end
      checks++; if (out_syndrome !== vsyn[i]) begin failures++; $display("FAIL dbl_syndrome got=%0h exp=%0h", out_syndrome, vsyn[i]); end
      checks++; if ({out_corrected, out_double} !== vflg[i]) begin failures++; $display("FAIL dbl_flags got=%0b exp=%0b", {out_corrected, out_double}, vflg[i]); end
      @(posedge clock); #1;
    end
    checks++; if (corr_count !== 16'd4) begin failures++; $display("FAIL cnt_corr_total got=%0d exp=4", corr_count); end
    checks++; if (double_count !== 16'd1) begin failures++; $display("FAIL cnt_dbl_total got=%0d exp=1", double_count); end
  endtask

  task automatic test_back_to_back();
    logic [15:0] exp_tbl  [8] = '{16'h000F, 16'h0033, 16'h0055, 16'h0096,
                                  16'h0303, 16'h0505, 16'h0906, 16'h1111};
    logic [15:0] flip_tbl [8] = '{16'h0000, 16'h0002, 16'h0000, 16'h0400,
                                  16'h8000, 16'h0000, 16'h0001, 16'h0010};
    int sent = 0;
    int rcvd = 0;
    bit saw_block = 1'b0;
    bit held_ok = 1'b1;
    bit prev_stall = 1'b0;
    logic [15:0] prev_code = '0;
    correct_en = 1'b1;
    for (int cyc = 0; cyc < 40 && rcvd < 8; cyc++) begin
      in_valid  = (sent < 8);
      in_code   = (sent < 8) ? (exp_tbl[sent] ^ flip_tbl[sent]) : 16'h0000;
      out_ready = !(cyc >= 4 && cyc < 9);
      @(negedge clock);
      if (!in_ready) saw_block = 1'b1;
      if (prev_stall && (!out_valid || out_code !== prev_code)) held_ok = 1'b0;
      prev_stall = out_valid && !out_ready;
      prev_code  = out_code;
      if (out_valid && out_ready) begin
        checks++;
        if (out_code !== exp_tbl[rcvd]) begin
          failures++; $display("FAIL bp_order idx=%0d got=%0h exp=%0h", rcvd, out_code, exp_tbl[rcvd]);
        end
        rcvd++;
      end
      if (in_valid && in_ready) sent++;
      @(posedge clock); #1;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    checks++; if (rcvd != 8) begin failures++; $display("FAIL bp_count got=%0d exp=8", rcvd); end
    checks++; if (saw_block !== 1'b1) begin failures++; $display("FAIL bp_in_ready_drop got=%0b exp=1", saw_block); end
    checks++; if (held_ok !== 1'b1) begin failures++; $display("FAIL bp_hold_stable got=%0b exp=1", held_ok); end
    repeat (2) @(posedge clock);
    #1;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL bp_no_duplicate got=%0h exp=0", out_valid); end
  endtask

  task automatic test_counters();
    clear_counts = 1'b1;
    @(posedge clock); #1;
    clear_counts = 1'b0;
    checks++; if (corr_count !== 16'd0 || double_count !== 16'd0) begin failures++; $display("FAIL cnt_clear got=%0d/%0d exp=0/0", corr_count, double_count); end
    checks++; if (corr_count2 !== 2'd0) begin failures++; $display("FAIL cnt2_clear got=%0d exp=0", corr_count2); end
    correct_en = 1'b1; out_ready = 1'b1; in_code = 16'h0020; in_valid = 1'b1;
    repeat (5) @(posedge clock);
    #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    checks++; if (corr_count !== 16'd5) begin failures++; $display("FAIL cnt_corr5 got=%0d exp=5", corr_count); end
    checks++; if (corr_count2 !== 2'd3) begin failures++; $display("FAIL cnt2_saturate got=%0d exp=3", corr_count2); end
    checks++; if (double_count2 !== 2'd0) begin failures++; $display("FAIL cnt2_dbl got=%0d exp=0", double_count2); end
    in_code = 16'h0020; in_valid = 1'b1;
    @(posedge clock); #1;
    in_valid = 1'b0;
    @(posedge clock); #1;
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL cnt_pre_clear_valid got=%0h exp=1", out_valid); end
    clear_counts = 1'b1;
    @(posedge clock); #1;
    clear_counts = 1'b0;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL cnt_clear_xfer_valid got=%0h exp=0", out_valid); end
    checks++; if (corr_count !== 16'd0) begin failures++; $display("FAIL cnt_clear_wins got=%0d exp=0", corr_count); end
    checks++; if (corr_count2 !== 2'd0) begin failures++; $display("FAIL cnt2_clear_wins got=%0d exp=0", corr_count2); end
  endtask

  task automatic test_midstream_reset();
    correct_en = 1'b1; out_ready = 1'b1; in_code = 16'h0028; in_valid = 1'b1;
    @(posedge clock); #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    checks++; if (double_count !== 16'd1) begin failures++; $display("FAIL rst_pre_dbl got=%0d exp=1", double_count); end
    in_code = 16'h0020; in_valid = 1'b1;
    @(posedge clock); #1;
    in_code = 16'h000F;
    @(posedge clock); #1;
    in_valid = 1'b0; out_ready = 1'b0;
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL rst_inflight got=%0h exp=1", out_valid); end
    reset_n = 1'b0; out_ready = 1'b1;
    @(posedge clock); #1;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rst_mid_valid got=%0h exp=0", out_valid); end
    checks++; if (double_count !== 16'd0 || corr_count !== 16'd0) begin failures++; $display("FAIL rst_mid_counts got=%0d/%0d exp=0/0", corr_count, double_count); end
    reset_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clock); #1;
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rst_stale cyc=%0d got=%0h exp=0", i, out_valid); end
    end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL rst_post_ready got=%0h exp=1", in_ready); end
    checks++; if (corr_count !== 16'd0) begin failures++; $display("FAIL rst_post_corr got=%0d exp=0", corr_count); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_clean();
    test_single();
    test_double();
    test_back_to_back();
    test_counters();
    test_midstream_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
